// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external ALU between NREQ requesters and
// captures each result in a single-entry response register with its own handshake.
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2,
  parameter int W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_mode,
  input  logic [4*NREQ-1:0]    req_sel,
  input  logic [NREQ-1:0]      req_cin,
  input  logic [W*NREQ-1:0]    req_a,
  input  logic [W*NREQ-1:0]    req_b,
  output logic                 alu_mode,
  output logic [3:0]           alu_sel,
  output logic                 alu_cin,
  output logic [W-1:0]         alu_a,
  output logic [W-1:0]         alu_b,
  input  logic [W-1:0]         alu_out,
  input  logic                 alu_cout,
  input  logic                 alu_cmp,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [W-1:0]         rsp_data,
  output logic                 rsp_cout,
  output logic                 rsp_cmp,
  output logic [15:0]          op_count
);

  typedef struct packed {
    logic         mode;
    logic [3:0]   sel;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  op_t [NREQ-1:0]  lane_op;
  op_t             gnt_op;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;
  logic            found;
  logic            gnt_vld;
  logic            can_accept;
  logic            rsp_fire;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane_op[i] = '{mode: req_mode[i], sel: req_sel[4*i +: 4], cin: req_cin[i],
                          a: req_a[W*i +: W], b: req_b[W*i +: W]};
  end

  assign can_accept = !rsp_valid || rsp_ready;
  assign rsp_fire   = rsp_valid && rsp_ready;

  // Scan from the highest offset down so the nearest valid requester to ptr wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr) + k) % NREQ);
      if (req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_vld = found && can_accept;

  always_comb begin
    req_ready = '0;
    gnt_op    = '0;
    if (gnt_vld) begin
      req_ready[gnt_idx] = 1'b1;
      gnt_op             = lane_op[gnt_idx];
    end
  end

  assign alu_mode = gnt_op.mode;
  assign alu_sel  = gnt_op.sel;
  assign alu_cin  = gnt_op.cin;
  assign alu_a    = gnt_op.a;
  assign alu_b    = gnt_op.b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
      rsp_cmp   <= 1'b0;
    end else if (gnt_vld) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_idx;
      rsp_data  <= alu_out;
      rsp_cout  <= alu_cout;
      rsp_cmp   <= alu_cmp;
      if (int'(gnt_idx) == NREQ - 1) ptr <= '0;
      else                           ptr <= gnt_idx + 1'b1;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            op_count <= '0;
    else if (rsp_fire && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stand-in, directed test-plan cases and a
// randomized run scored against a transaction-level arbitration model.
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0, req_mode = '0, req_cin = '0;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_sel = '0;
  logic [W*NREQ-1:0] req_a = '0, req_b = '0;
  logic              alu_mode, alu_cin, alu_cout, alu_cmp;
  logic [3:0]        alu_sel;
  logic [W-1:0]      alu_a, alu_b, alu_out;
  logic              rsp_valid, rsp_cout, rsp_cmp;
  logic              rsp_ready = 1'b0;
  logic [ID_W-1:0]   rsp_id;
  logic [W-1:0]      rsp_data;
  logic [15:0]       op_count;

  int checks = 0;
  int errors = 0;

  int           m_ptr = 0;
  logic         m_valid = 1'b0;
  int           m_id = 0;
  logic [W-1:0] m_data = '0;
  logic         m_cout = 1'b0, m_cmp = 1'b0;
  int           m_cnt = 0;

  logic [3:0] sel_tab [5] = '{4'b1001, 4'b0110, 4'b1011, 4'b1110, 4'b0000};

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_sel(req_sel),
    .req_cin(req_cin), .req_a(req_a), .req_b(req_b),
    .alu_mode(alu_mode), .alu_sel(alu_sel), .alu_cin(alu_cin), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_cmp(alu_cmp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_cmp(rsp_cmp), .op_count(op_count)
  );

  // Stand-in ALU: returns {cmp, cout, out}. Arithmetic subtract reports cout=1 when A-B-1+cin < 0.
  function automatic logic [W+1:0] alu_fn(input logic mode, input logic [3:0] sel,
                                          input logic cin, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    if (mode) begin
      case (sel)
        4'b0110: r = {1'b0, a ^ b};
        4'b1011: r = {1'b0, a & b};
        4'b1110: r = {1'b0, a | b};
        default: r = {1'b0, ~a};
      endcase
      return {2'b00, r[W-1:0]};
    end
    case (sel)
      4'b1001: r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      4'b0110: begin
        r = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
        r[W] = ~r[W];
      end
      default: r = {1'b0, a} + {{W{1'b0}}, cin};
    endcase
    return {(a == b), r};
  endfunction

  assign {alu_cmp, alu_cout, alu_out} = alu_fn(alu_mode, alu_sel, alu_cin, alu_a, alu_b);

  function automatic int m_grant();
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    int g;
    g = m_grant();
    if ((!m_valid || rsp_ready) && g >= 0) return NREQ'(1) << g;
    return '0;
  endfunction

  task automatic set_req(input int i, input logic v, input logic mode, input logic [3:0] sel,
                         input logic cin, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i] = v;  req_mode[i] = mode; req_sel[4*i +: 4] = sel;
    req_cin[i]   = cin; req_a[W*i +: W] = a; req_b[W*i +: W] = b;
  endtask

  task automatic rand_lane(input int i, input logic force_valid);
    set_req(i, force_valid | 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            sel_tab[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
  endtask

  // Advance one clock: the model takes the edge using the inputs currently driven.
  task automatic tick();
    int g;
    logic acc;
    acc = !m_valid || rsp_ready;
    g   = m_grant();
    if (m_valid && rsp_ready && m_cnt != 16'hFFFF) m_cnt++;
    if (acc && g >= 0) begin
      {m_cmp, m_cout, m_data} = alu_fn(req_mode[g], req_sel[4*g +: 4], req_cin[g],
                                       req_a[W*g +: W], req_b[W*g +: W]);
      m_id = g; m_valid = 1'b1; m_ptr = (g + 1) % NREQ;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    m_ptr = 0; m_valid = 1'b0; m_id = 0; m_data = '0; m_cout = 1'b0; m_cmp = 1'b0; m_cnt = 0;
  endtask

  task automatic do_reset();
    req_valid = '0; rsp_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    model_clear();
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    checks++; if ({rsp_id, rsp_data, rsp_cout, rsp_cmp} !== '0) begin errors++;
      $display("FAIL reset_rsp: got id=%h data=%h cout=%b cmp=%b want zeros", rsp_id, rsp_data, rsp_cout, rsp_cmp); end
    checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0000", op_count); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 1, 0, 4'b1001, 0, 16'h0001, 16'h0002);
    tick();
    req_valid = '0;
    checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_cmp} !== {1'b1, 2'd0, 16'h0003, 2'b00}) begin errors++;
      $display("FAIL add_req0: got v=%b id=%0d data=%h cout=%b cmp=%b want 1/0/0003/0/0", rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_cmp); end
    tick();
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL count_one: got %0d want 1", op_count); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain: got valid=%b want 0", rsp_valid); end
    set_req(2, 1, 0, 4'b1001, 1, 16'hFFFF, 16'h0000);
    tick();
    req_valid = '0;
    checks++; if ({rsp_id, rsp_data, rsp_cout} !== {2'd2, 16'h0000, 1'b1}) begin errors++;
      $display("FAIL add_carry_req2: got id=%0d data=%h cout=%b want 2/0000/1", rsp_id, rsp_data, rsp_cout); end
    set_req(1, 1, 0, 4'b0110, 0, 16'h1234, 16'h1234);
    tick();
    checks++; if ({rsp_id, rsp_data, rsp_cout, rsp_cmp} !== {2'd1, 16'hFFFF, 2'b11}) begin errors++;
      $display("FAIL sub_eq_req1: got id=%0d data=%h cout=%b cmp=%b want 1/FFFF/1/1", rsp_id, rsp_data, rsp_cout, rsp_cmp); end
    set_req(1, 1, 1, 4'b0110, 0, 16'h00FF, 16'h0F0F);
    tick();
    req_valid = '0;
    checks++; if ({rsp_id, rsp_data, rsp_cout, rsp_cmp} !== {2'd1, 16'h0FF0, 2'b00}) begin errors++;
      $display("FAIL xor_req1: got id=%0d data=%h cout=%b cmp=%b want 1/0FF0/0/0", rsp_id, rsp_data, rsp_cout, rsp_cmp); end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) rand_lane(i, 1'b1);
    for (int n = 0; n < 6; n++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (n % 4))) begin errors++;
        $display("FAIL rr_ready[%0d]: got %b want one-hot %0d", n, req_ready, n % 4); end
      tick();
      checks++; if (rsp_id !== 2'(n % 4) || rsp_data !== m_data || rsp_valid !== 1'b1) begin errors++;
        $display("FAIL rr_rsp[%0d]: got id=%0d data=%h v=%b want id=%0d data=%h v=1", n, rsp_id, rsp_data, rsp_valid, n % 4, m_data); end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 1, 0, 4'b1001, 0, 16'h0010, 16'h0020);
    tick();
    rsp_ready = 1'b0;
    set_req(0, 1, 0, 4'b1001, 0, 16'h0100, 16'h0200);
    set_req(1, 1, 0, 4'b0110, 1, 16'h0005, 16'h0003);
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", n, req_ready); end
      tick();
      checks++; if ({rsp_valid, rsp_id, rsp_data, op_count} !== {1'b1, 2'd0, 16'h0030, 16'd0}) begin errors++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d data=%h cnt=%0d want 1/0/0030/0", n, rsp_valid, rsp_id, rsp_data, op_count); end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_cout, op_count} !== {1'b1, 2'd1, 16'h0002, 1'b0, 16'd1}) begin errors++;
      $display("FAIL bp_release_rsp: got v=%b id=%0d data=%h cout=%b cnt=%0d want 1/1/0002/0/1", rsp_valid, rsp_id, rsp_data, rsp_cout, op_count); end
    tick(); tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] last_gnt, exp_r;
    logic [4+W+W+1:0] exp_alu;
    int g;
    do_reset();
    last_gnt = '0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_gnt[i]) rand_lane(i, 1'b0);
        else if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_r = m_ready();
      g = m_grant();
      exp_alu = (exp_r != '0) ? {req_mode[g], req_sel[4*g +: 4], req_cin[g], req_a[W*g +: W], req_b[W*g +: W]} : '0;
      checks++; if (req_ready !== exp_r) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, req_ready, exp_r); end
      checks++; if ({alu_mode, alu_sel, alu_cin, alu_a, alu_b} !== exp_alu) begin errors++;
        $display("FAIL rnd_alu[%0d]: got %h want %h", n, {alu_mode, alu_sel, alu_cin, alu_a, alu_b}, exp_alu); end
      last_gnt = exp_r;
      tick();
      checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_cmp, op_count} !==
                    {m_valid, ID_W'(m_id), m_data, m_cout, m_cmp, 16'(m_cnt)}) begin errors++;
        $display("FAIL rnd_rsp[%0d]: got v=%b id=%0d d=%h c=%b q=%b n=%0d want v=%b id=%0d d=%h c=%b q=%b n=%0d", n,
                 rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_cmp, op_count, m_valid, m_id, m_data, m_cout, m_cmp, m_cnt); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) rand_lane(i, 1'b1);
    for (int n = 0; n < 6; n++) tick();
    checks++; if (rsp_valid !== 1'b1 || op_count !== 16'd5) begin errors++;
      $display("FAIL pre_reset: got v=%b cnt=%0d want 1/5", rsp_valid, op_count); end
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_cmp, op_count} !== '0) begin errors++;
      $display("FAIL async_clear: got v=%b id=%0d data=%h cout=%b cmp=%b cnt=%0d want zeros",
               rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_cmp, op_count); end
    #1 rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL post_reset_ready: got %b want 0001", req_ready); end
    tick();
    checks++; if (rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin errors++;
      $display("FAIL post_reset_grant: got id=%0d v=%b want 0/1", rsp_id, rsp_valid); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
